// File: rtl/split_sched_if.sv
// split_sched_if: handshake and status bundle for the split scheduler.
//   slave  modport : scheduler side (split_sched)
//   master modport : controller / evaluator side (testbench or parent)
// Signals:
//   start, split_mask        - run request and enabled-split mask
//   eval_req, split_sel      - request to the evaluator at index split_sel
//   eval_ack, eval_res       - evaluator result strobe and value
//   busy, done, sat          - run status, end-of-run pulse, run verdict
//   fail_idx, timeout_err    - failing split index, timeout flag
//   eval_cnt                 - acknowledges consumed in the current/last run
interface split_sched_if #(
    parameter int NUM_SPLITS = 8,
    parameter int IDX_W      = 3
);
    logic                  start;
    logic [NUM_SPLITS-1:0] split_mask;
    logic                  eval_req;
    logic [IDX_W-1:0]      split_sel;
    logic                  eval_ack;
    logic                  eval_res;
    logic                  busy;
    logic                  done;
    logic                  sat;
    logic [IDX_W-1:0]      fail_idx;
    logic                  timeout_err;
    logic [IDX_W:0]        eval_cnt;

    modport slave (
        input  start, split_mask, eval_ack, eval_res,
        output eval_req, split_sel, busy, done, sat, fail_idx, timeout_err, eval_cnt
    );

    modport master (
        output start, split_mask, eval_ack, eval_res,
        input  eval_req, split_sel, busy, done, sat, fail_idx, timeout_err, eval_cnt
    );
endinterface

// File: rtl/split_sched.sv
// split_sched: sequences a set of split constraint evaluators in ascending
// index order, skipping disabled splits, and reports whether all of them hold.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - split_sched_if.slave (start/mask in, req/sel out, ack/res in, status out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results of the last run held
// REQ   | eval_req high for split_sel, waiting for ack or timeout
// DONE  | one-cycle done pulse, then back to IDLE
module split_sched #(
    parameter int NUM_SPLITS = 8,
    parameter int IDX_W      = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic         clk,
    input  logic         rst,
    split_sched_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_SPLITS-1:0] r_mask;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  r_eval_req;
    logic [IDX_W-1:0]      r_split_sel;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sat;
    logic [IDX_W-1:0]      r_fail_idx;
    logic                  r_timeout_err;
    logic [CNT_W-1:0]      r_eval_cnt;

    logic [IDX_W-1:0]      w_first_idx;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_has_next;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;

    // Lowest enabled index in the incoming mask, and lowest enabled index
    // above the current selection in the latched mask. Both are found in the
    // same cycle so back-to-back requests have no gap.
    always_comb begin
        w_first_idx = '0;
        w_next_idx  = '0;
        w_has_next  = 1'b0;
        for (int i = NUM_SPLITS - 1; i >= 0; i--) begin
            if (bus.split_mask[i]) begin
                w_first_idx = IDX_W'(i);
            end
            if (r_mask[i] && (i > int'(r_split_sel))) begin
                w_next_idx = IDX_W'(i);
                w_has_next = 1'b1;
            end
        end
    end

    assign w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    assign w_cnt_inc  = (r_eval_cnt == CNT_W'(NUM_SPLITS)) ? r_eval_cnt : r_eval_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mask        <= '0;
            r_wait_cnt    <= '0;
            r_eval_req    <= 1'b0;
            r_split_sel   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_sat         <= 1'b0;
            r_fail_idx    <= '0;
            r_timeout_err <= 1'b0;
            r_eval_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mask        <= bus.split_mask;
                        r_sat         <= 1'b0;
                        r_fail_idx    <= '0;
                        r_timeout_err <= 1'b0;
                        r_eval_cnt    <= '0;
                        r_wait_cnt    <= '0;
                        r_busy        <= 1'b1;
                        if (|bus.split_mask) begin
                            r_state     <= ST_REQ;
                            r_split_sel <= w_first_idx;
                            r_eval_req  <= 1'b1;
                        end else begin
                            // Nothing to evaluate: vacuously satisfied.
                            r_state <= ST_DONE;
                            r_sat   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack always wins over a timeout in the same cycle.
                    if (bus.eval_ack) begin
                        r_eval_cnt <= w_cnt_inc;
                        if (!bus.eval_res) begin
                            r_state    <= ST_DONE;
                            r_eval_req <= 1'b0;
                            r_done     <= 1'b1;
                            r_sat      <= 1'b0;
                            r_fail_idx <= r_split_sel;
                        end else if (w_has_next) begin
                            r_split_sel <= w_next_idx;
                            r_wait_cnt  <= '0;
                        end else begin
                            r_state    <= ST_DONE;
                            r_eval_req <= 1'b0;
                            r_done     <= 1'b1;
                            r_sat      <= 1'b1;
                        end
                    end else if (w_wait_nxt == WAIT_W'(TIMEOUT)) begin
                        r_state       <= ST_DONE;
                        r_eval_req    <= 1'b0;
                        r_done        <= 1'b1;
                        r_sat         <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_fail_idx    <= r_split_sel;
                    end else begin
                        r_wait_cnt <= w_wait_nxt;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_eval_req <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.eval_req    = r_eval_req;
    assign bus.split_sel   = r_split_sel;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.sat         = r_sat;
    assign bus.fail_idx    = r_fail_idx;
    assign bus.timeout_err = r_timeout_err;
    assign bus.eval_cnt    = r_eval_cnt;
endmodule
